// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, encoded owner index
// and a per-ownership hold counter with an optional preemption limit.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic [7:0]       gnt,
    output logic [2:0]       gnt_id,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] busy_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             HOLD_EN  = (MAX_HOLD != 0);

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] win_id;
    logic       win_found;
    logic [2:0] idx;
    logic       owner_req;
    logic       hold_done;

    // First active requester scanning upward from ptr with wrap from 7 to 0.
    always_comb begin
        win_id    = 3'd0;
        win_found = 1'b0;
        idx       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign owner_req = req[gnt_id];
    assign hold_done = HOLD_EN && (busy_cnt == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= 8'd1 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        busy_cnt  <= CNT_W'(1);
                        ptr       <= win_id + 3'd1;
                    end
                end
                GRANT: begin
                    // A release and a limit hit on the same edge both land in the same clear.
                    if (!owner_req || hold_done) begin
                        state     <= IDLE;
                        gnt       <= 8'd0;
                        gnt_id    <= 3'd0;
                        gnt_valid <= 1'b0;
                        busy_cnt  <= '0;
                    end else if (busy_cnt != CNT_MAX) begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: three instances cover unlimited hold, a hold
// limit of 2 and a hold limit of 3, all sharing clock, reset and requests.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] g0, g2, g3;
    logic [2:0] id0, id2, id3;
    logic       v0, v2, v3;
    logic [7:0] b0, b2, b3;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g0), .gnt_id(id0), .gnt_valid(v0), .busy_cnt(b0)
    );
    rr_arbiter8 #(.MAX_HOLD(2), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g2), .gnt_id(id2), .gnt_valid(v2), .busy_cnt(b2)
    );
    rr_arbiter8 #(.MAX_HOLD(3), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g3), .gnt_id(id3), .gnt_valid(v3), .busy_cnt(b3)
    );

    logic [19:0] obs0, obs2, obs3;
    assign obs0 = {g0, id0, v0, b0};
    assign obs2 = {g2, id2, v2, b2};
    assign obs3 = {g3, id3, v3, b3};

    localparam logic [19:0] IDLE_V = 20'h0;

    // Expected {gnt, gnt_id, gnt_valid, busy_cnt} while owner o holds for b cycles.
    function automatic logic [19:0] exp_g(input int o, input int b);
        logic [7:0] oh;
        oh = 8'd1 << o;
        exp_g = {oh, 3'(o), 1'b1, 8'(b)};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        #3;
        n_checks++;
        if ({obs0, obs2, obs3} !== {IDLE_V, IDLE_V, IDLE_V}) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%h/%h want all 0", obs0, obs2, obs3);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({obs0, obs2, obs3} !== {IDLE_V, IDLE_V, IDLE_V}) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %h/%h/%h want all 0", c, obs0, obs2, obs3);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0000_0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (obs0 !== exp_g(2, c)) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", c, obs0, exp_g(2, c));
            end
        end
        req = 8'd0;
        tick();
        n_checks++;
        if (obs0 !== IDLE_V) begin
            n_fail++;
            $display("FAIL single_release: got %h want %h", obs0, IDLE_V);
        end
    endtask

    task automatic test_rotation();
        int o;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            o = k % 8;
            for (int c = 1; c <= 2; c++) begin
                tick();
                n_checks++;
                if (obs2 !== exp_g(o, c)) begin
                    n_fail++;
                    $display("FAIL rotate owner%0d c%0d: got %h want %h", o, c, obs2, exp_g(o, c));
                end
            end
            tick();
            n_checks++;
            if (obs2 !== IDLE_V) begin
                n_fail++;
                $display("FAIL rotate_gap after %0d: got %h want %h", o, obs2, IDLE_V);
            end
        end
        req = 8'd0;
    endtask

    task automatic test_fairness();
        do_reset();
        req = 8'b0010_0000;
        tick();
        n_checks++;
        if (obs0 !== exp_g(5, 1)) begin
            n_fail++;
            $display("FAIL fair_own5: got %h want %h", obs0, exp_g(5, 1));
        end
        req = 8'd0;
        tick();
        n_checks++;
        if (obs0 !== IDLE_V) begin
            n_fail++;
            $display("FAIL fair_release: got %h want %h", obs0, IDLE_V);
        end
        req = 8'b0010_0001;
        tick();
        n_checks++;
        if (obs0 !== exp_g(0, 1)) begin
            n_fail++;
            $display("FAIL fair_next: got %h want %h", obs0, exp_g(0, 1));
        end
        req = 8'd0;
    endtask

    task automatic test_preempt();
        do_reset();
        req = 8'b1000_0000;
        for (int r = 0; r < 3; r++) begin
            for (int c = 1; c <= 3; c++) begin
                tick();
                n_checks++;
                if (obs3 !== exp_g(7, c)) begin
                    n_fail++;
                    $display("FAIL preempt r%0d c%0d: got %h want %h", r, c, obs3, exp_g(7, c));
                end
            end
            tick();
            n_checks++;
            if (obs3 !== IDLE_V) begin
                n_fail++;
                $display("FAIL preempt_gap r%0d: got %h want %h", r, obs3, IDLE_V);
            end
        end
        req = 8'd0;
    endtask

    task automatic test_release_at_limit();
        do_reset();
        req = 8'b0000_0010;
        tick();
        tick();
        n_checks++;
        if (obs2 !== exp_g(1, 2)) begin
            n_fail++;
            $display("FAIL limit_hold: got %h want %h", obs2, exp_g(1, 2));
        end
        req = 8'd0;
        tick();
        n_checks++;
        if (obs2 !== IDLE_V) begin
            n_fail++;
            $display("FAIL limit_release: got %h want %h", obs2, IDLE_V);
        end
        tick();
        n_checks++;
        if (obs2 !== IDLE_V) begin
            n_fail++;
            $display("FAIL limit_stay_idle: got %h want %h", obs2, IDLE_V);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'b0000_1000;
        for (int c = 1; c <= 5; c++) tick();
        n_checks++;
        if (obs0 !== exp_g(3, 5)) begin
            n_fail++;
            $display("FAIL areset_pre: got %h want %h", obs0, exp_g(3, 5));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs0 !== IDLE_V) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h want %h", obs0, IDLE_V);
        end
        req = 8'b0001_1000;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs0 !== exp_g(3, 1)) begin
            n_fail++;
            $display("FAIL areset_regrant: got %h want %h", obs0, exp_g(3, 1));
        end
        req = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'd0;
        test_reset();
        test_single();
        test_rotation();
        test_fairness();
        test_preempt();
        test_release_at_limit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
